// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared CPU types, memory-stage state encoding and access helpers.
// Revision 1.0
`default_nettype none

package mycpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ALU = 4'd1,
    OP_LB  = 4'd2,
    OP_LH  = 4'd3,
    OP_LW  = 4'd4,
    OP_LBU = 4'd5,
    OP_LHU = 4'd6,
    OP_SB  = 4'd7,
    OP_SH  = 4'd8,
    OP_SW  = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_WAIT = 2'd2,
    MA_DONE = 2'd3
  } ma_state_t;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  // Bit positions inside the {AdES, AdEL} exception vector.
  localparam int EXC_ADEL = 0;
  localparam int EXC_ADES = 1;

  function automatic logic is_load(op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(op_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic [2:0] access_size(op_t op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      OP_LW, OP_SW:         return SIZE_WORD;
      default:              return SIZE_BYTE;
    endcase
  endfunction

  function automatic logic is_misaligned(op_t op, logic [1:0] addr_lo);
    case (access_size(op))
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return addr_lo != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed byte/half of a load word and extends it.
// Revision 1.0
`default_nettype none

module mem_load_align
  import mycpu_pkg::*;
(
  input  op_t         op,
  input  logic [1:0]  addr_lo,
  input  word_t       raw,
  output word_t       data
);

  word_t shifted;

  always_comb begin
    shifted = raw >> {addr_lo, 3'b000};
    data    = '0;
    case (op)
      OP_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  data = {24'h000000, shifted[7:0]};
      OP_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  data = {16'h0000, shifted[15:0]};
      OP_LW:   data = raw;
      default: data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/memory_access.sv
// memory_access: MEM pipeline stage; issues one data-bus transaction per op and
// hands the aligned result or address exception to writeback.  Revision 1.0
`default_nettype none

module memory_access
  import mycpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  op_t         in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_exc,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_exc,
  output logic [31:0] out_addr
);

  ma_state_t   state, state_next;
  op_t         op_q;
  word_t       addr_q, wdata_q, result_q, load_data;
  logic [1:0]  exc_q, exc_in;
  logic        kill;
  logic        accept, in_mis, go_bus, bus_done;

  mem_load_align u_align (
    .op      (op_q),
    .addr_lo (addr_q[1:0]),
    .raw     (dresp_data),
    .data    (load_data)
  );

  assign accept   = (state == MA_IDLE) && in_valid && !flush;
  assign in_mis   = is_misaligned(in_op, in_addr[1:0]);
  assign go_bus   = (is_load(in_op) || is_store(in_op)) && !in_exc && !in_mis;
  assign bus_done = dresp_data_ok &&
                    (((state == MA_REQ) && dresp_addr_ok) || (state == MA_WAIT));

  always_comb begin
    exc_in = '0;
    if (!in_exc) begin
      exc_in[EXC_ADEL] = in_mis && is_load(in_op);
      exc_in[EXC_ADES] = in_mis && is_store(in_op);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MA_IDLE: if (accept) state_next = go_bus ? MA_REQ : MA_DONE;
      MA_REQ: begin
        if (dresp_addr_ok) begin
          if (dresp_data_ok) state_next = (kill || flush) ? MA_IDLE : MA_DONE;
          else               state_next = MA_WAIT;
        end
      end
      MA_WAIT: if (dresp_data_ok) state_next = (kill || flush) ? MA_IDLE : MA_DONE;
      MA_DONE: if (flush || out_ready) state_next = MA_IDLE;
      default: state_next = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MA_IDLE;
      kill     <= 1'b0;
      op_q     <= OP_NOP;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      exc_q    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q    <= in_op;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        exc_q   <= exc_in;
        // Non-memory ops carry the ALU value straight through; faulted ops return 0.
        result_q <= (!is_load(in_op) && !is_store(in_op) && !in_exc) ? in_addr : '0;
      end
      if (bus_done) result_q <= is_load(op_q) ? load_data : '0;
      if (((state == MA_REQ) || (state == MA_WAIT)) && flush) kill <= 1'b1;
      if (state_next == MA_IDLE) kill <= 1'b0;
    end
  end

  always_comb begin
    dreq_strobe = '0;
    dreq_data   = '0;
    case (op_q)
      OP_SB: begin
        dreq_strobe = 4'b0001 << addr_q[1:0];
        dreq_data   = {4{wdata_q[7:0]}};
      end
      OP_SH: begin
        dreq_strobe = 4'b0011 << addr_q[1:0];
        dreq_data   = {2{wdata_q[15:0]}};
      end
      OP_SW: begin
        dreq_strobe = 4'b1111;
        dreq_data   = wdata_q;
      end
      default: ;
    endcase
  end

  assign in_ready   = (state == MA_IDLE);
  assign dreq_valid = (state == MA_REQ);
  assign dreq_addr  = addr_q;
  assign dreq_size  = access_size(op_q);
  assign out_valid  = (state == MA_DONE);
  assign out_data   = result_q;
  assign out_exc    = exc_q;
  assign out_addr   = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
// tb_memory_access: scoreboard bench for the memory_access stage.
// Revision 1.0
`default_nettype none

module tb_memory_access;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_exc, flush;
  logic        in_ready;
  op_t         in_op;
  logic [31:0] in_addr, in_wdata;
  logic        dreq_valid;
  logic [31:0] dreq_addr, dreq_data;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data, out_addr;
  logic [1:0]  out_exc;

  memory_access dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_exc(in_exc), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_exc(out_exc), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  exc;
    logic [31:0] addr;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] model_load(op_t op, logic [31:0] a, logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = a[1] ? raw[31:16] : raw[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      OP_LW:   return raw;
      default: return 32'h0;
    endcase
  endfunction

  task automatic run_op(input op_t op, input logic [31:0] a, input logic [31:0] wd,
                        input logic exc_in, input int a_lat, input int d_lat,
                        input logic [31:0] raw);
    exp_t e;
    logic ld, st, mis, bus;
    logic [3:0] strb;
    logic [31:0] sdata;
    logic [2:0] sz;
    int acc, n;
    ld  = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    st  = op inside {OP_SB, OP_SH, OP_SW};
    mis = ((op inside {OP_LH, OP_LHU, OP_SH}) && a[0]) ||
          ((op inside {OP_LW, OP_SW}) && (a[1:0] != 2'b00));
    bus = (ld || st) && !exc_in && !mis;
    sz  = (op inside {OP_LW, OP_SW}) ? 3'd2 : (op inside {OP_LH, OP_LHU, OP_SH}) ? 3'd1 : 3'd0;
    case (op)
      OP_SB:   begin strb = 4'b0001 << a[1:0]; sdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]}; end
      OP_SH:   begin strb = a[1] ? 4'b1100 : 4'b0011; sdata = {wd[15:0], wd[15:0]}; end
      OP_SW:   begin strb = 4'b1111; sdata = wd; end
      default: begin strb = 4'b0000; sdata = 32'h0; end
    endcase
    e.addr = a;
    e.exc  = exc_in ? 2'b00 : {mis && st, mis && ld};
    e.data = (exc_in || mis || st) ? 32'h0 : ld ? model_load(op, a, raw) : a;
    e.lat  = bus ? (2 + a_lat + d_lat) : 1;
    sb.push_back(e);

    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_addr = a; in_wdata = wd; in_exc = exc_in;
    acc = cyc;
    step();
    in_valid = 1'b0; in_op = OP_NOP; in_addr = '0; in_wdata = '0; in_exc = 1'b0;
    if (bus) begin
      check("dreq_valid", 32'(dreq_valid), 32'd1);
      check("dreq_addr", dreq_addr, a);
      check("dreq_size", 32'(dreq_size), 32'(sz));
      check("dreq_strobe", 32'(dreq_strobe), 32'(strb));
      if (st) check("dreq_data", dreq_data, sdata);
      repeat (a_lat) begin
        step();
        check("dreq_hold_valid", 32'(dreq_valid), 32'd1);
        check("dreq_hold_addr", dreq_addr, a);
      end
      dresp_addr_ok = 1'b1;
      if (d_lat == 0) begin dresp_data_ok = 1'b1; dresp_data = raw; end
      step();
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      if (d_lat > 0) begin
        check("dreq_drop", 32'(dreq_valid), 32'd0);
        repeat (d_lat - 1) step();
        dresp_data_ok = 1'b1; dresp_data = raw;
        step();
        dresp_data_ok = 1'b0;
      end
      dresp_data = 32'hA5A5A5A5;
    end else begin
      check("no_dreq", 32'(dreq_valid), 32'd0);
    end
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    check("out_valid", 32'(out_valid), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("latency", 32'(cyc - acc), 32'(e.lat));
      check("out_data", out_data, e.data);
      check("out_exc", 32'(out_exc), 32'(e.exc));
      check("out_addr", out_addr, e.addr);
      step();
      check("out_hold_valid", 32'(out_valid), 32'd1);
      check("out_hold_data", out_data, e.data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = OP_NOP; in_addr = '0; in_wdata = '0;
    in_exc = 1'b0; flush = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    dresp_data = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dreq_valid", 32'(dreq_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_out_exc", 32'(out_exc), 32'd0);
    check("rst_dreq_strobe", 32'(dreq_strobe), 32'd0);

    run_op(OP_ALU, 32'h12345678, 32'h0, 1'b0, 0, 0, 32'h0);
    run_op(OP_LW,  32'h00001000, 32'h0, 1'b0, 1, 2, 32'hDEADBEEF);
    run_op(OP_LB,  32'h00001003, 32'h0, 1'b0, 0, 0, 32'h80112233);
    run_op(OP_LBU, 32'h00001003, 32'h0, 1'b0, 0, 1, 32'h80112233);
    run_op(OP_LH,  32'h00001002, 32'h0, 1'b0, 2, 0, 32'h80112233);
    run_op(OP_LHU, 32'h00001002, 32'h0, 1'b0, 0, 3, 32'h80112233);
    run_op(OP_LB,  32'h00001001, 32'h0, 1'b0, 0, 0, 32'h80112233);
    run_op(OP_SH,  32'h00002002, 32'h1234ABCD, 1'b0, 1, 1, 32'h0);
    run_op(OP_SB,  32'h00002001, 32'h000000EF, 1'b0, 0, 0, 32'h0);
    run_op(OP_SW,  32'h00002000, 32'hCAFEF00D, 1'b0, 0, 2, 32'h0);
    run_op(OP_SW,  32'h00002001, 32'h11111111, 1'b0, 0, 0, 32'h0);
    run_op(OP_LW,  32'h00002002, 32'h0, 1'b0, 0, 0, 32'h0);
    run_op(OP_LHU, 32'h00001001, 32'h0, 1'b0, 0, 0, 32'h0);
    run_op(OP_LW,  32'h00002002, 32'h0, 1'b1, 0, 0, 32'h0);
    run_op(OP_ALU, 32'h0BADF00D, 32'h0, 1'b1, 0, 0, 32'h0);

    // Flush during WAIT: bus completes but nothing reaches writeback.
    in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h3000;
    step();
    in_valid = 1'b0;
    dresp_addr_ok = 1'b1; step(); dresp_addr_ok = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_wait_ov", 32'(out_valid), 32'd0);
    step();
    dresp_data_ok = 1'b1; dresp_data = 32'h55555555; step(); dresp_data_ok = 1'b0;
    check("flush_wait_ready", 32'(in_ready), 32'd1);
    check("flush_wait_ov2", 32'(out_valid), 32'd0);
    step();
    check("flush_wait_ov3", 32'(out_valid), 32'd0);
    run_op(OP_LW, 32'h00003004, 32'h0, 1'b0, 0, 1, 32'h01020304);

    // Flush with in_valid in IDLE: op ignored.
    in_valid = 1'b1; in_op = OP_ALU; in_addr = 32'h77; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", 32'(in_ready), 32'd1);
    check("flush_idle_ov", 32'(out_valid), 32'd0);

    // Flush in DONE drops the pending result.
    in_valid = 1'b1; in_op = OP_ALU; in_addr = 32'h99;
    step();
    in_valid = 1'b0;
    check("done_ov", 32'(out_valid), 32'd1);
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_done_ov", 32'(out_valid), 32'd0);
    check("flush_done_ready", 32'(in_ready), 32'd1);

    // Reset while in REQ.
    in_valid = 1'b1; in_op = OP_SW; in_addr = 32'h4000; in_wdata = 32'hFFFFFFFF;
    step();
    in_valid = 1'b0;
    check("req_valid", 32'(dreq_valid), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_req_dreq", 32'(dreq_valid), 32'd0);
    check("rst_req_strobe", 32'(dreq_strobe), 32'd0);
    check("rst_req_addr", dreq_addr, 32'd0);
    check("rst_req_ready", 32'(in_ready), 32'd1);

    // Reset mid-WAIT, then a late data_ok.
    in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h5000;
    step();
    in_valid = 1'b0;
    dresp_addr_ok = 1'b1; step(); dresp_addr_ok = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    dresp_data_ok = 1'b1; dresp_data = 32'h12121212; step(); dresp_data_ok = 1'b0;
    check("late_ok_ov", 32'(out_valid), 32'd0);
    check("late_ok_ready", 32'(in_ready), 32'd1);
    check("late_ok_data", out_data, 32'd0);
    step();
    check("late_ok_ov2", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
